multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32I subset core: ADD/SUB/AND/OR/SRL, ADDI/ORI, LW, SW, BEQ.
- Sequences each instruction through fetch/decode/execute/memory/writeback.
- Drives the datapath mux selects and write enables, and generates the {ALUOp1, ALUOp0} pair consumed by ALU_Control.
- Waits on a single shared instruction/data memory via a ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instruction register bits [6:0]; sampled only in DECODE.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified externally by ALU zero (BEQ).
- pc_source  out  1  0 = ALU result, 1 = ALUOut register.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 = PC, 1 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- ALUOp1  out  1  to ALU_Control.
- ALUOp0  out  1  to ALU_Control.
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode.
- instret  out  CNT_W  retired-instruction count.
- state_dbg  out  4  current state encoding.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high: while reset = 1 at a rising edge, state <= FETCH and instret <= 0. All outputs are forced to 0 while reset is high.
- Output style: Moore outputs decoded from state. The only exceptions are ir_write and pc_write in FETCH, which are gated by mem_ready.
- Default outputs: any output not listed for a state is 0, including ALUOp = 00.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALUOp=00, pc_source=0. ir_write = pc_write = mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=10, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - any other -> TRAP
- EXEC_R: alu_src_a=1, alu_src_b=00, ALUOp=10 -> ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=10, ALUOp=11 -> ALU_WB.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ALUOp=00. Goes to MEM_READ if the latched opcode is a load, else MEM_WRITE.
  - Opcode bit 5 is latched in DECODE into is_store.
- MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready, then LOAD_WB.
- MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready, then FETCH; this retires the instruction.
- LOAD_WB: reg_write=1, mem_to_reg=1 -> FETCH (retire).
- ALU_WB: reg_write=1, mem_to_reg=0 -> FETCH (retire).
- BRANCH: alu_src_a=1, alu_src_b=00, ALUOp=01, pc_write_cond=1, pc_source=1 -> FETCH (retire).
- TRAP: illegal_instr=1 for exactly one cycle -> FETCH. No retire; the PC was already advanced in FETCH, so execution continues at PC+4.
- Request stability: mem_read and mem_write stay high and stable during wait cycles. They never assert in the same cycle.
- Cycle counts with mem_ready tied high: R = 4, I = 4, LW = 5, SW = 4, BEQ = 3, illegal = 3.
- instret: +1 on each retire transition into FETCH. Wraps modulo 2^CNT_W with no saturation.
- Unreachable state encodings go to FETCH on the next edge with all outputs 0.
- Reset mid-operation: the state is abandoned on the reset edge, any pending memory request drops with the forced-zero outputs, and no retire is counted.
- Reset has priority over every transition, including a retire in the same cycle.

Decomposition:
- Shared package rv_ctrl_pkg:
  - 4-bit state localparams: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_READ=5, MEM_WRITE=6, LOAD_WB=7, ALU_WB=8, BRANCH=9, TRAP=10.
  - Opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH.
  - ALUOp codes: ALUOP_ADD=00, ALUOP_BR=01, ALUOP_R=10, ALUOP_I=11.
  - alu_src_b codes.
- One sub-module, mc_ctrl_decode: purely combinational state + mem_ready -> control outputs.
- The top level holds the state register, is_store, the next-state logic and instret.

Test Plan:
- Reset with reset=1 for 2 cycles, mem_ready=1 -> all outputs 0, instret=0, state_dbg=0; first cycle after release has mem_read=1, ir_write=1, pc_write=1.
- opcode=0110011, mem_ready=1 -> states 0,1,2,8; EXEC_R shows ALUOp=10; reg_write=1 in cycle 4; instret 0->1.
- opcode=0000011, mem_ready low for 3 cycles in MEM_READ -> state_dbg holds at 5 for 4 cycles with mem_read=1, i_or_d=1; then LOAD_WB with mem_to_reg=1; 8 cycles total; instret +1.
- opcode=0100011 then opcode=1100011 back-to-back -> SW passes 6 with mem_write=1; BEQ passes 9 with ALUOp=01, pc_write_cond=1, pc_source=1; 7 cycles total; instret +2.
- opcode=1111111 -> states 0,1,10; illegal_instr high exactly 1 cycle; instret unchanged.
- reset asserted while in MEM_WRITE with mem_ready=0 -> next cycle state_dbg=0, mem_write=0, instret=0; CNT_W=4 run of 16 R-type instructions -> instret wraps to 0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset control unit: state codes,
// opcode values, ALUOp and ALU B-source selects, plus the retire rule.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_I    = 4'd3,
        MEM_ADDR  = 4'd4,
        MEM_READ  = 4'd5,
        MEM_WRITE = 4'd6,
        LOAD_WB   = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        TRAP      = 4'd10
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // A store retires only once memory accepts it; every other retiring
    // state finishes unconditionally on its way back to FETCH.
    function automatic logic retires(input logic [3:0] st, input logic ready);
        return (st == LOAD_WB) || (st == ALU_WB) || (st == BRANCH) ||
               ((st == MEM_WRITE) && ready);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Output decoder for the multicycle controller: maps the current state (and
// mem_ready during FETCH) onto datapath selects and enables.
module mc_ctrl_decode (
    input  logic       reset_i,
    input  logic [3:0] state_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       pc_source_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       illegal_instr_o
);
    import rv_ctrl_pkg::*;

    // Everything defaults low so reset and unused encodings come out inert.
    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_source_o     = 1'b0;
        i_or_d_o        = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_RS2;
        alu_op_o        = ALUOP_ADD;
        illegal_instr_o = 1'b0;

        if (!reset_i) begin
            case (state_i)
                FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = SRCB_FOUR;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                DECODE: begin
                    alu_src_b_o = SRCB_IMM;
                end
                EXEC_R: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALUOP_R;
                end
                EXEC_I: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = SRCB_IMM;
                    alu_op_o    = ALUOP_I;
                end
                MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = SRCB_IMM;
                end
                MEM_READ: begin
                    mem_read_o = 1'b1;
                    i_or_d_o   = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write_o = 1'b1;
                    i_or_d_o    = 1'b1;
                end
                LOAD_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                end
                ALU_WB: begin
                    reg_write_o = 1'b1;
                end
                BRANCH: begin
                    alu_src_a_o     = 1'b1;
                    alu_op_o        = ALUOP_BR;
                    pc_write_cond_o = 1'b1;
                    pc_source_o     = 1'b1;
                end
                TRAP: begin
                    illegal_instr_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I-subset core: sequences each
// instruction, latches load/store direction and counts retired instructions.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ALUOp1,
    output logic             ALUOp0,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_dbg
);
    import rv_ctrl_pkg::*;

    logic [3:0]       state_q, state_d;
    logic             is_store_q, is_store_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [1:0]       alu_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            is_store_q <= 1'b0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            instret_q  <= instret_d;
        end
    end

    // Opcode is only trusted in DECODE; loads and stores share MEM_ADDR, so
    // opcode bit 5 is kept to pick the memory direction afterwards.
    always_comb begin
        state_d    = FETCH;
        is_store_d = is_store_q;
        instret_d  = instret_q;

        case (state_q)
            FETCH:     state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                is_store_d = opcode[5];
                case (opcode)
                    OP_R:              state_d = EXEC_R;
                    OP_I:              state_d = EXEC_I;
                    OP_LOAD, OP_STORE: state_d = MEM_ADDR;
                    OP_BRANCH:         state_d = BRANCH;
                    default:           state_d = TRAP;
                endcase
            end
            EXEC_R:    state_d = ALU_WB;
            EXEC_I:    state_d = ALU_WB;
            MEM_ADDR:  state_d = is_store_q ? MEM_WRITE : MEM_READ;
            MEM_READ:  state_d = mem_ready ? LOAD_WB : MEM_READ;
            MEM_WRITE: state_d = mem_ready ? FETCH : MEM_WRITE;
            LOAD_WB:   state_d = FETCH;
            ALU_WB:    state_d = FETCH;
            BRANCH:    state_d = FETCH;
            TRAP:      state_d = FETCH;
            default:   state_d = FETCH;
        endcase

        if (retires(state_q, mem_ready)) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    mc_ctrl_decode u_decode (
        .reset_i         (reset),
        .state_i         (state_q),
        .mem_ready_i     (mem_ready),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .pc_source_o     (pc_source),
        .i_or_d_o        (i_or_d),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .ir_write_o      (ir_write),
        .mem_to_reg_o    (mem_to_reg),
        .reg_write_o     (reg_write),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .alu_op_o        (alu_op),
        .illegal_instr_o (illegal_instr)
    );

    assign ALUOp1    = alu_op[1];
    assign ALUOp0    = alu_op[0];
    assign instret   = reset ? '0 : instret_q;
    assign state_dbg = reset ? 4'd0 : state_q;

    // The shared memory port can only serve one direction per cycle.
    assert property (@(posedge clk) disable iff (reset) !(mem_read && mem_write));

endmodule
